// File: rtl/ad_ip_jesd204_tpl_cfg_master.sv
// Single-outstanding AXI4-Lite master that turns a cmd/rsp handshake into
// register accesses on the JESD204 TPL configuration port, with a per-transaction timeout.
module ad_ip_jesd204_tpl_cfg_master #(
  parameter int ADDRESS_WIDTH  = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     up_clk,
  input  logic                     up_rst,

  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [31:0]              cmd_wdata,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_timeout,

  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,

  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,

  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  input  logic [1:0]               m_axi_bresp,

  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  output logic [ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]               m_axi_arprot,

  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RSP,
    S_TO_RSP,
    S_DRAIN
  } state_t;

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t                     state;
  state_t                     state_next;

  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [31:0]                wdata_q;
  logic                       is_wr;
  logic                       aw_done;
  logic                       w_done;
  logic                       axi_done;
  logic [CNT_W-1:0]           timeout_cnt;

  logic                       accept;
  logic                       aw_hs;
  logic                       w_hs;
  logic                       ar_hs;
  logic                       b_ok;
  logic                       r_ok;
  logic                       axi_cmpl;
  logic                       timeout_hit;
  logic                       busy;

  // NOTE: cmd_ready is the only decoded output; gating it with the async reset
  // keeps it low for the whole reset pulse, not just from the next edge.
  assign cmd_ready = (state == S_IDLE) && !up_rst;
  assign accept    = cmd_valid && cmd_ready;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  // A write response only counts once both address and data were accepted earlier.
  assign b_ok  = m_axi_bvalid && m_axi_bready && aw_done && w_done;
  assign r_ok  = m_axi_rvalid && m_axi_rready;

  assign axi_cmpl    = is_wr ? b_ok : r_ok;
  assign timeout_hit = TIMEOUT_EN && (timeout_cnt == CNT_MAX);
  assign busy        = (state == S_WRITE) || (state == S_READ);

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hf;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next state defaults to the current one so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = cmd_wr ? S_WRITE : S_READ;
      end
      S_WRITE, S_READ: begin
        if (axi_cmpl)         state_next = S_RSP;
        else if (timeout_hit) state_next = S_TO_RSP;
      end
      S_RSP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      S_TO_RSP: begin
        if (rsp_ready) state_next = (axi_done || axi_cmpl) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (axi_cmpl) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      is_wr         <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      axi_done      <= 1'b0;
      timeout_cnt   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q        <= cmd_addr;
        wdata_q       <= cmd_wdata;
        is_wr         <= cmd_wr;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
        axi_done      <= 1'b0;
        timeout_cnt   <= '0;
        m_axi_awvalid <= cmd_wr;
        m_axi_wvalid  <= cmd_wr;
        m_axi_bready  <= cmd_wr;
        m_axi_arvalid <= !cmd_wr;
        m_axi_rready  <= !cmd_wr;
      end else begin
        // Channels keep running after a timeout until the slave finishes.
        if (aw_hs) begin
          m_axi_awvalid <= 1'b0;
          aw_done       <= 1'b1;
        end
        if (w_hs) begin
          m_axi_wvalid <= 1'b0;
          w_done       <= 1'b1;
        end
        if (ar_hs) m_axi_arvalid <= 1'b0;
        if (b_ok)  m_axi_bready  <= 1'b0;
        if (r_ok)  m_axi_rready  <= 1'b0;
        if (axi_cmpl) axi_done <= 1'b1;
        if (busy && (timeout_cnt != CNT_MAX)) timeout_cnt <= timeout_cnt + CNT_W'(1);
      end

      if (busy && axi_cmpl) begin
        rsp_valid   <= 1'b1;
        rsp_resp    <= is_wr ? m_axi_bresp : m_axi_rresp;
        rsp_rdata   <= is_wr ? 32'h0 : m_axi_rdata;
        rsp_timeout <= 1'b0;
      end else if (busy && timeout_hit) begin
        rsp_valid   <= 1'b1;
        rsp_resp    <= 2'b10;
        rsp_rdata   <= 32'h0;
        rsp_timeout <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_cfg_master.sv
// Self-checking bench: delay-programmable AXI4-Lite slave, directed vector table,
// reset sequences and randomized transactions checked against a latency model.
module tb_ad_ip_jesd204_tpl_cfg_master;

  localparam int T = 16;

  logic        up_clk;
  logic        up_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        m_axi_awvalid, m_axi_awready;
  logic [11:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [11:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  ad_ip_jesd204_tpl_cfg_master #(
    .ADDRESS_WIDTH (12),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .up_clk       (up_clk),
    .up_rst       (up_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awprot (m_axi_awprot),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arprot (m_axi_arprot),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp)
  );

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          aw_d, w_d, b_d, ar_d, r_d, rsp_w;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    int          rsp_lat, idle_lat;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          to;
    int          aw_hi, w_hi, ar_hi;
  } exp_t;

  typedef struct {
    exp_t        r;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [6:0]  attr;
    int          unstable;
  } obs_t;

  typedef struct {
    txn_t t;
    exp_t x;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Slave programming, changed only between transactions.
  int          s_aw_d, s_w_d, s_b_d, s_ar_d, s_r_d;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;
  always @(posedge up_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: each ready/valid appears a programmed number of cycles after it is due.
  initial begin : slave
    bit aw_got, w_got, ar_got, aw_pend, w_pend, ar_pend, b_pend, r_pend;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge up_clk);
      if (up_rst) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      end else begin
        if (aw_pend) begin m_axi_awready = 0; aw_got = 1; aw_cnt = 0; end
        if (w_pend)  begin m_axi_wready  = 0; w_got  = 1; w_cnt  = 0; end
        if (ar_pend) begin m_axi_arready = 0; ar_got = 1; ar_cnt = 0; end
        if (b_pend) begin
          m_axi_bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0;
        end else if (aw_got && w_got && !m_axi_bvalid) begin
          if (b_cnt == s_b_d) begin m_axi_bvalid = 1; m_axi_bresp = s_bresp; end
          else b_cnt++;
        end
        if (r_pend) begin
          m_axi_rvalid = 0; ar_got = 0; r_cnt = 0;
        end else if (ar_got && !m_axi_rvalid) begin
          if (r_cnt == s_r_d) begin m_axi_rvalid = 1; m_axi_rdata = s_rdata; m_axi_rresp = s_rresp; end
          else r_cnt++;
        end
        if (m_axi_awvalid && !aw_got && !m_axi_awready) begin
          if (aw_cnt == s_aw_d) m_axi_awready = 1; else aw_cnt++;
        end
        if (m_axi_wvalid && !w_got && !m_axi_wready) begin
          if (w_cnt == s_w_d) m_axi_wready = 1; else w_cnt++;
        end
        if (m_axi_arvalid && !ar_got && !m_axi_arready) begin
          if (ar_cnt == s_ar_d) m_axi_arready = 1; else ar_cnt++;
        end
      end
      aw_pend = m_axi_awvalid && m_axi_awready;
      w_pend  = m_axi_wvalid  && m_axi_wready;
      ar_pend = m_axi_arvalid && m_axi_arready;
      b_pend  = m_axi_bvalid  && m_axi_bready;
      r_pend  = m_axi_rvalid  && m_axi_rready;
    end
  end

  task automatic do_reset();
    @(negedge up_clk);
    #2 up_rst = 1'b1;
    @(negedge up_clk);
    @(negedge up_clk);
    #2 up_rst = 1'b0;
  endtask

  // Issues one command and observes it until the block is idle again.
  task automatic run_txn(input txn_t t, output obs_t o);
    int  k, e;
    bit  got;
    o.r.rsp_lat = -1; o.r.idle_lat = -1; o.r.resp = 0; o.r.rdata = 0; o.r.to = 0;
    o.r.aw_hi = 0; o.r.w_hi = 0; o.r.ar_hi = 0;
    o.addr = 0; o.wdata = 0; o.attr = 0; o.unstable = 0;
    s_aw_d = t.aw_d; s_w_d = t.w_d; s_b_d = t.b_d; s_ar_d = t.ar_d; s_r_d = t.r_d;
    s_bresp = t.bresp; s_rresp = t.rresp; s_rdata = t.rdata;
    rsp_ready = 1'b0;
    @(negedge up_clk);
    cmd_valid = 1'b1; cmd_wr = t.wr; cmd_addr = t.addr; cmd_wdata = t.wdata;
    k = cyc + 1;
    @(negedge up_clk);
    cmd_valid = 1'b0;
    got = 0;
    e   = 0;
    for (int n = 0; n < 200; n++) begin
      if (n == 0) begin
        o.addr  = t.wr ? m_axi_awaddr : m_axi_araddr;
        o.wdata = m_axi_wdata;
        o.attr  = t.wr ? {m_axi_awprot, m_axi_wstrb} : {m_axi_arprot, 4'hf};
      end
      o.r.aw_hi += int'(m_axi_awvalid);
      o.r.w_hi  += int'(m_axi_wvalid);
      o.r.ar_hi += int'(m_axi_arvalid);
      if (got) begin
        if (rsp_rdata !== o.r.rdata || rsp_resp !== o.r.resp || rsp_timeout !== o.r.to ||
            (!rsp_ready && !rsp_valid)) o.unstable++;
      end else if (rsp_valid) begin
        got = 1; e = cyc;
        o.r.rsp_lat = cyc - k;
        o.r.resp = rsp_resp; o.r.rdata = rsp_rdata; o.r.to = rsp_timeout;
      end
      if (cmd_ready) begin
        o.r.idle_lat = cyc - k;
        break;
      end
      if (got && (cyc - e) == t.rsp_w) rsp_ready = 1'b1;
      @(negedge up_clk);
    end
    rsp_ready = 1'b0;
    if (o.r.idle_lat < 0) do_reset();
  endtask

  task automatic compare(input string tag, input txn_t t, input obs_t o, input exp_t x);
    check({tag, ".rsp_lat"},  o.r.rsp_lat,  x.rsp_lat);
    check({tag, ".idle_lat"}, o.r.idle_lat, x.idle_lat);
    check({tag, ".resp"},     o.r.resp,     x.resp);
    check({tag, ".rdata"},    o.r.rdata,    x.rdata);
    check({tag, ".timeout"},  o.r.to,       x.to);
    check({tag, ".aw_hi"},    o.r.aw_hi,    x.aw_hi);
    check({tag, ".w_hi"},     o.r.w_hi,     x.w_hi);
    check({tag, ".ar_hi"},    o.r.ar_hi,    x.ar_hi);
    check({tag, ".unstable"}, o.unstable,   0);
    check({tag, ".addr"},     o.addr,       t.addr);
    check({tag, ".attr"},     o.attr,       7'h0f);
    if (t.wr) check({tag, ".wdata"}, o.wdata, t.wdata);
  endtask

  // Reference: completion edge from channel delays, then timeout/drain arbitration.
  function automatic exp_t model(input txn_t t);
    exp_t x;
    int   c, hs, r;
    if (t.wr) begin
      hs = (t.aw_d > t.w_d ? t.aw_d : t.w_d) + 1;
      c  = hs + 1 + t.b_d;
    end else begin
      c = t.ar_d + 1 + 1 + t.r_d;
    end
    x.aw_hi = t.wr ? t.aw_d + 1 : 0;
    x.w_hi  = t.wr ? t.w_d + 1 : 0;
    x.ar_hi = t.wr ? 0 : t.ar_d + 1;
    if (c <= T + 1) begin
      x.rsp_lat  = c;
      x.idle_lat = c + t.rsp_w + 1;
      x.resp     = t.wr ? t.bresp : t.rresp;
      x.rdata    = t.wr ? 32'h0 : t.rdata;
      x.to       = 0;
    end else begin
      r          = T + 1 + t.rsp_w + 1;
      x.rsp_lat  = T + 1;
      x.idle_lat = (r > c) ? r : c;
      x.resp     = 2'b10;
      x.rdata    = 32'h0;
      x.to       = 1;
    end
    return x;
  endfunction

  function automatic vec_t mkv(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                               input int aw_d, input int w_d, input int b_d, input int ar_d,
                               input int r_d, input int rsp_w, input logic [1:0] bresp,
                               input logic [1:0] rresp, input logic [31:0] rdata,
                               input int lat, input int idle, input logic [1:0] resp,
                               input logic [31:0] xrd, input bit to,
                               input int awh, input int wh, input int arh);
    vec_t v;
    v.t.wr = wr; v.t.addr = addr; v.t.wdata = wdata;
    v.t.aw_d = aw_d; v.t.w_d = w_d; v.t.b_d = b_d; v.t.ar_d = ar_d; v.t.r_d = r_d;
    v.t.rsp_w = rsp_w; v.t.bresp = bresp; v.t.rresp = rresp; v.t.rdata = rdata;
    v.x.rsp_lat = lat; v.x.idle_lat = idle; v.x.resp = resp; v.x.rdata = xrd; v.x.to = to;
    v.x.aw_hi = awh; v.x.w_hi = wh; v.x.ar_hi = arh;
    return v;
  endfunction

  vec_t vecs[10];
  vec_t post_rst;

  initial begin
    obs_t o;
    txn_t t;

    //            wr addr    wdata         aw w  b  ar r  rw bresp rresp rdata         lat idle resp xrdata        to awh wh arh
    vecs[0] = mkv(1, 12'h040, 32'h0000_0003, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h0,        2,  3,   2'd0, 32'h0,        0, 1,  1, 0);
    vecs[1] = mkv(0, 12'h000, 32'h0,         0, 0, 0, 3, 2, 0, 2'd0, 2'd0, 32'h0A02_0000, 7,  8,  2'd0, 32'h0A02_0000, 0, 0, 0, 4);
    vecs[2] = mkv(1, 12'h104, 32'hCAFE_F00D, 5, 0, 0, 0, 0, 0, 2'd2, 2'd0, 32'h0,        7,  8,   2'd2, 32'h0,        0, 6,  1, 0);
    vecs[3] = mkv(0, 12'h208, 32'h0,         0, 0, 0, 40, 0, 0, 2'd0, 2'd0, 32'hDEAD_BEEF, 17, 42, 2'd2, 32'h0,       1, 0,  0, 41);
    vecs[4] = mkv(0, 12'h00c, 32'h0,         0, 0, 0, 0, 1, 10, 2'd0, 2'd1, 32'h1234_5678, 3, 14, 2'd1, 32'h1234_5678, 0, 0, 0, 1);
    vecs[5] = mkv(0, 12'h010, 32'h0,         0, 0, 0, 0, 15, 0, 2'd0, 2'd0, 32'h5555_AAAA, 17, 18, 2'd0, 32'h5555_AAAA, 0, 0, 0, 1);
    vecs[6] = mkv(1, 12'h044, 32'h0000_0011, 2, 3, 20, 0, 0, 2, 2'd0, 2'd0, 32'h0,       17, 25,  2'd2, 32'h0,        1, 3,  4, 0);
    vecs[7] = mkv(1, 12'h048, 32'h0000_0022, 2, 3, 14, 0, 0, 5, 2'd1, 2'd0, 32'h0,       17, 23,  2'd2, 32'h0,        1, 3,  4, 0);
    vecs[8] = mkv(1, 12'h04c, 32'h0000_0033, 0, 0, 14, 0, 0, 0, 2'd3, 2'd0, 32'h0,       16, 17,  2'd3, 32'h0,        0, 1,  1, 0);
    vecs[9] = mkv(0, 12'h014, 32'h0,         0, 0, 0, 0, 16, 0, 2'd0, 2'd0, 32'h7777_8888, 17, 18, 2'd2, 32'h0,       1, 0,  0, 1);
    post_rst = mkv(0, 12'h020, 32'h0,        0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 32'hA5A5_A5A5, 3, 4,  2'd0, 32'hA5A5_A5A5, 0, 0, 0, 2);

    up_rst = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    s_aw_d = 0; s_w_d = 0; s_b_d = 0; s_ar_d = 0; s_r_d = 0; s_bresp = 0; s_rresp = 0; s_rdata = 0;

    // Reset values
    #1;
    check("rst.cmd_ready", cmd_ready, 0);
    repeat (3) @(negedge up_clk);
    check("rst.ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                       rsp_valid, rsp_timeout, cmd_ready}, 8'h00);
    check("rst.rsp_rdata", rsp_rdata, 0);
    check("rst.rsp_resp", rsp_resp, 0);
    check("rst.addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata}, 0);
    check("rst.tied", {m_axi_awprot, m_axi_arprot, m_axi_wstrb}, 10'h00f);
    #2 up_rst = 1'b0;
    @(negedge up_clk);
    check("rst.release_cmd_ready", cmd_ready, 1);

    // Directed vectors
    foreach (vecs[i]) begin
      run_txn(vecs[i].t, o);
      compare($sformatf("vec%0d", i), vecs[i].t, o, vecs[i].x);
    end

    // Reset while the write address is still waiting for awready
    t = vecs[0].t;
    t.aw_d = 30;
    s_aw_d = t.aw_d; s_w_d = 0; s_b_d = 0;
    @(negedge up_clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 12'h050; cmd_wdata = 32'h1;
    @(negedge up_clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge up_clk);
    check("midrst.awvalid_before", {m_axi_awvalid, m_axi_awready, m_axi_bready}, 3'b101);
    #2 up_rst = 1'b1;
    #1;
    check("midrst.valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                            m_axi_rready, rsp_valid, cmd_ready}, 7'h00);
    @(negedge up_clk);
    #2 up_rst = 1'b0;
    @(negedge up_clk);
    check("midrst.cmd_ready", cmd_ready, 1);
    run_txn(post_rst.t, o);
    compare("post_rst", post_rst.t, o, post_rst.x);

    // Randomized transactions against the latency model
    for (int i = 0; i < 40; i++) begin
      t.wr    = 1'($urandom_range(0, 1));
      t.addr  = 12'($urandom);
      t.wdata = $urandom;
      t.aw_d  = $urandom_range(0, 6);
      t.w_d   = $urandom_range(0, 6);
      t.b_d   = $urandom_range(0, 12);
      t.ar_d  = $urandom_range(0, 8);
      t.r_d   = $urandom_range(0, 12);
      t.rsp_w = $urandom_range(0, 3);
      t.bresp = 2'($urandom);
      t.rresp = 2'($urandom);
      t.rdata = $urandom;
      run_txn(t, o);
      compare($sformatf("rand%0d", i), t, o, model(t));
    end

    repeat (2) @(negedge up_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_cfg_master.md
# ad_ip_jesd204_tpl_cfg_master

Single-outstanding AXI4-Lite master that turns a simple command/response handshake into register reads and writes on the 12-bit AXI4-Lite configuration port of the JESD204 TPL cores (common, channel and TPL register pages). It is the initiator side of that port. A local sequencer, soft CPU bridge or bring-up FSM uses it to program the TPL DAC/ADC without a processor interconnect. A per-transaction timeout keeps the requester from hanging on a dead slave while staying AXI-legal.

## Interface
- ADDRESS_WIDTH, 12, width of cmd_addr and m_axi_awaddr/araddr (byte address).
- TIMEOUT_CYCLES, 1024, cycles from command acceptance to forced timeout response; 0 disables the timeout.

Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- up_clk  in  1  sole clock; all logic is rising-edge.
- up_rst  in  1  asynchronous, active-high reset.

Command and response ports:
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, command accepted on cmd_valid&cmd_ready.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  ADDRESS_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_resp  out  2  AXI resp code; 2'b10 on timeout.
- rsp_timeout  out  1  response generated by the timeout.

AXI4-Lite master ports:
- m_axi_awvalid/awready/awaddr/awprot: awprot is tied to 3'b000.
- m_axi_wvalid/wready/wdata/wstrb: wstrb is tied to 4'hf.
- m_axi_bvalid/bready/bresp.
- m_axi_arvalid/arready/araddr/arprot: arprot is tied to 3'b000.
- m_axi_rvalid/rready/rdata/rresp.

## Operation
- States: IDLE, WRITE, READ, RSP, TO_RSP, DRAIN. Reset state is IDLE.
- cmd_ready is 1 only in IDLE. It is 0 while up_rst is high.
- Command capture: the accept edge registers addr and wdata.
  - For a write, the state goes to WRITE and awvalid, wvalid and bready all rise.
  - For a read, the state goes to READ and arvalid and rready rise.
- WRITE state:
  - awvalid drops the cycle after its aw handshake; wvalid drops the cycle after its w handshake. The two channels are independent, in either order or simultaneous.
  - bready is held until the b handshake.
  - A b handshake before both the aw and w handshakes is ignored (protocol error). It is not counted as completion.
- READ state: arvalid drops after its handshake. rready is held until the r handshake, which captures rdata and rresp.
- Completion (b or r handshake): go to RSP with rsp_valid=1.
  - rsp_resp is set to bresp or rresp.
  - rsp_rdata is set to rdata for reads and 0 for writes.
  - rsp_timeout=0.
- RSP/TO_RSP: the response outputs are held stable until rsp_ready.
- Timeout counter:
  - It is cleared at command accept and increments every cycle in WRITE/READ.
  - When it reaches TIMEOUT_CYCLES with no completion on that edge, the state goes to TO_RSP with rsp_valid=1, rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
  - If completion and expiry coincide, completion wins.
- During TO_RSP/DRAIN, any un-handshaken awvalid/wvalid/arvalid stays asserted, and bready/rready stay asserted, until the transaction completes on AXI. The late response is discarded.
- Exit from TO_RSP:
  - If the rsp handshake happens and AXI is already complete, go to IDLE.
  - Otherwise go to DRAIN, then to IDLE on AXI completion.
- Reset mid-transaction: all valids and readies drop immediately (asynchronous) and the state returns to IDLE. Any outstanding transaction is abandoned.

## Timing
- Reset values:
  - cmd_ready=0 while up_rst is high, 1 after release.
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0.
  - All m_axi valid and ready outputs are 0; addresses and data are 0.
- All outputs except cmd_ready are registered; cmd_ready is decoded from state.
- Command accepted at edge k: AXI valids are high from cycle k+1.
- Slave handshake at edge j: rsp_valid is high from cycle j+1.
- rsp handshake at edge m: cmd_ready is high from cycle m+1.
- Back-to-back commands: with a zero-wait slave and rsp_ready held high, one transaction completes every 4 cycles.
- Timeout: rsp_valid rises TIMEOUT_CYCLES+1 cycles after the accept edge.

## Test plan
- Write to addr 0x040 with data 0x0000_0003, slave awready/wready/bvalid all immediate, bresp=0: awvalid and wvalid are high for exactly 1 cycle; rsp_valid, rsp_resp=0 and rsp_rdata=0 arrive 2 cycles after accept; cmd_ready returns the cycle after rsp_ready.
- Read of addr 0x000 where the slave returns 0x0A02_0000 after 3 wait cycles on arready and 2 on rvalid: rsp_rdata=0x0A02_0000, rsp_timeout=0, arvalid held until arready.
- Write with wready 5 cycles before awready, then bresp=2'b10: wvalid drops first, awvalid is held; rsp_resp=2'b10.
- TIMEOUT_CYCLES=16, slave never asserts arready for 40 cycles then responds: a timeout response (resp 2'b10, timeout=1) arrives at accept+17; arvalid stays high; cmd_ready stays 0 until the late r handshake; the late rdata never appears on rsp_rdata.
- rsp_ready held low for 10 cycles after a read completes: rsp outputs are stable and cmd_ready stays 0.
- up_rst pulsed while awvalid is high and awready is low: all valids go 0 immediately; after release cmd_ready=1 and a subsequent read completes normally.
- Completion and timeout expiry on the same edge: a normal response with rsp_timeout=0.
